// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch slice
package inst_fetch_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    // Canonical no-op encoding (addi x0, x0, 0)
    localparam word_t OP_NOP           = 32'h0000_0013;
    localparam addr_t NULL_PTR         = 32'h0000_0000;
    localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

    // One queued instruction together with the PC it was fetched from
    typedef struct packed {
        addr_t pc;
        word_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - cache request/reply and decode handshake bundle
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    // dual-port instruction cache side
    logic  en_rx;
    addr_t pcx;
    logic  hitx;
    word_t instx;
    logic  en_ry;
    addr_t pcy;
    logic  hity;
    word_t insty;

    // decode side
    logic  out_valid;
    addr_t out_pc;
    word_t out_inst;
    logic  out_ready;

    modport master (
        output en_rx, pcx, en_ry, pcy, out_valid, out_pc, out_inst,
        input  hitx, instx, hity, insty, out_ready
    );

    modport slave (
        input  en_rx, pcx, en_ry, pcy, out_valid, out_pc, out_inst,
        output hitx, instx, hity, insty, out_ready
    );

endinterface

// File: rtl/inst_fetch_unit_inst_queue_2w1r.sv
// rtl/inst_fetch_unit_inst_queue_2w1r.sv - in-order instruction FIFO, two writes and one read per cycle
module inst_queue_2w1r
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,        // low: every register holds
    input  logic               flush,     // empties the queue, drops this cycle's push/pop
    input  logic [1:0]         wr_cnt,    // 0, 1 or 2 entries written in order
    input  fetch_entry_t       wr_data0,
    input  fetch_entry_t       wr_data1,
    input  logic               rd_en,
    output logic               rd_valid,
    output fetch_entry_t       rd_data,
    output logic [PTR_W:0]     count
);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   head_p1;
    logic               pop;

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_en;
    assign head_p1  = head_q + PTR_W'(1);
    assign count    = count_q;

    // Head entry is presented combinationally; an empty queue reads as all zeros
    always_comb begin
        rd_data = '{pc: NULL_PTR, inst: '0};
        if (rd_valid) begin
            rd_data = mem_q[tail_q];
        end
    end

    // Pointer, occupancy and storage updates; flush wins over push/pop
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en) begin
            if (flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (wr_cnt != 2'd0) begin
                    mem_d[head_q] = wr_data0;
                end
                if (wr_cnt == 2'd2) begin
                    mem_d[head_p1] = wr_data1;
                end
                head_d  = head_q + PTR_W'(wr_cnt);
                tail_d  = tail_q + PTR_W'(pop);
                count_d = count_q + (PTR_W+1)'(wr_cnt) - (PTR_W+1)'(pop);
            end
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch stage: PC steering, cache reply intake and instruction queue
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int    DEPTH    = 8,
    parameter int    PTR_W    = 3,
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                jump_en,
    input  addr_t               jump_addr,
    inst_fetch_unit_if.master   bus
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    addr_t           pc_q, pc_d;
    logic            rsp_valid_q, rsp_valid_d;
    addr_t           pc_next;
    addr_t           pc_adv;
    logic [1:0]      push_cnt;
    logic            hx, hy;
    logic [PTR_W:0]  count;
    logic [PTR_W:0]  free;
    fetch_entry_t    wr_data0, wr_data1;
    fetch_entry_t    rd_data;
    logic            rd_valid;

    // The reply seen now always belongs to pc_q, so only the hit bits matter
    assign hx   = rsp_valid_q & bus.hitx;
    assign hy   = rsp_valid_q & bus.hity;
    // Space is judged before this cycle's pop, so a pop never enables a same-cycle push
    assign free = DEPTH_C - count;

    assign wr_data0 = '{pc: pc_q,              inst: bus.instx};
    assign wr_data1 = '{pc: pc_q + 32'd4,      inst: bus.insty};

    // Push decision: port y only counts behind a port-x hit to keep program order
    always_comb begin
        push_cnt = 2'd0;
        pc_adv   = pc_q;
        if (hx && hy && (free >= (PTR_W+1)'(2))) begin
            push_cnt = 2'd2;
            pc_adv   = pc_q + 32'd8;
        end else if (hx && (free != '0)) begin
            push_cnt = 2'd1;
            pc_adv   = pc_q + 32'd4;
        end
    end

    // Next PC priority: reset, stall, redirect, sequential advance
    always_comb begin
        pc_next     = pc_adv;
        rsp_valid_d = rdy & ~rst;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (!rdy) begin
            pc_next = pc_q;
        end else if (jump_en) begin
            pc_next = jump_addr;
        end
        pc_d = pc_next;
    end

    // PC of the group whose reply is due, plus whether a reply is expected at all
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.en_rx = rdy & ~rst;
    assign bus.en_ry = rdy & ~rst;
    assign bus.pcx   = pc_next;
    assign bus.pcy   = pc_next + 32'd4;

    inst_queue_2w1r #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .flush    (jump_en),
        .wr_cnt   (push_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_en    (bus.out_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count)
    );

    assign bus.out_valid = rd_valid;
    assign bus.out_pc    = rd_data.pc;
    assign bus.out_inst  = rd_data.inst;

endmodule
